// File: rtl/mul_arb_pkg.sv
// Shared types for the Booth-multiplier arbiter: FSM state encoding and requester count.
package mul_arb_pkg;
    localparam int N_REQ = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        START = 2'b01,
        WAIT  = 2'b10,
        RESP  = 2'b11
    } arb_state_t;
endpackage

// File: rtl/mul_arb_rr.sv
// Two-way round-robin picker: on a tie the requester that was not served last wins.
module mul_arb_rr
    import mul_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic             last,
    output logic [N_REQ-1:0] win
);
    always_comb begin
        win = '0;
        case (req)
            2'b01:   win = 2'b01;
            2'b10:   win = 2'b10;
            2'b11:   win = last ? 2'b01 : 2'b10;
            default: win = '0;
        endcase
    end
endmodule

// File: rtl/mul_arbiter.sv
// Shares one Booth multiplier core between two requesters (req/gnt in, done/ack out).
// Optional WAIT-state watchdog enabled with `define MUL_ARB_WDOG_EN.
module mul_arbiter
    import mul_arb_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int TMO   = 12
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req,
    input  logic [2*WIDTH-1:0]     a_in,
    input  logic [2*WIDTH-1:0]     b_in,
    output logic [N_REQ-1:0]       gnt,
    output logic [N_REQ-1:0]       done,
    input  logic [N_REQ-1:0]       ack,
    output logic [2*WIDTH-1:0]     res,
    output logic                   err,
    output logic                   mul_start,
    output logic [WIDTH-1:0]       mul_a,
    output logic [WIDTH-1:0]       mul_b,
    input  logic                   mul_fin,
    input  logic [2*WIDTH-1:0]     mul_p
);
    arb_state_t       state_q, state_d;
    logic             owner;
    logic             last;
    logic [N_REQ-1:0] win;
    logic             wd_exp;

    mul_arb_rr u_rr (
        .req  (req),
        .last (last),
        .win  (win)
    );

`ifdef MUL_ARB_WDOG_EN
    localparam int CW = $clog2(TMO + 1);
    logic [CW-1:0] wd_cnt;
    logic          err_q;

    assign wd_exp = (wd_cnt == CW'(TMO - 1));
    assign err    = err_q;

    // Expiry only matters when the core is silent; a finish in the same cycle wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            wd_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            case (state_q)
                START: wd_cnt <= '0;
                WAIT: begin
                    if (mul_fin)     err_q  <= 1'b0;
                    else if (wd_exp) err_q  <= 1'b1;
                    else             wd_cnt <= wd_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end
`else
    assign wd_exp = 1'b0;
    assign err    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (|req) state_d = START;
            START: state_d = WAIT;
            WAIT:  if (mul_fin || wd_exp) state_d = RESP;
            RESP:  if (ack[owner]) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        gnt       = '0;
        done      = '0;
        mul_start = 1'b0;
        case (state_q)
            START: begin
                gnt[owner] = 1'b1;
                mul_start  = 1'b1;
            end
            RESP:    done[owner] = 1'b1;
            default: ;
        endcase
    end

    // Operand/owner capture, result capture and round-robin pointer update.
    always_ff @(posedge clk) begin
        if (reset) begin
            owner <= 1'b0;
            last  <= 1'b1;
            mul_a <= '0;
            mul_b <= '0;
            res   <= '0;
        end else begin
            case (state_q)
                IDLE: if (|req) begin
                    owner <= win[1];
                    mul_a <= win[1] ? a_in[WIDTH +: WIDTH] : a_in[0 +: WIDTH];
                    mul_b <= win[1] ? b_in[WIDTH +: WIDTH] : b_in[0 +: WIDTH];
                end
                WAIT: begin
                    if (mul_fin)     res <= mul_p;
                    else if (wd_exp) res <= '0;
                end
                RESP: if (ack[owner]) last <= owner;
                default: ;
            endcase
        end
    end
endmodule

// File: doc/mul_arbiter.md
# mul_arbiter

Shares the single Booth multiplier datapath and its control unit between two requesters. Accepts operand pairs over a request/grant handshake, restarts the multiplier through a start pulse, and waits for its finish flag. It then captures the product and returns it to the owning requester over a done/ack handshake. It sits between the client logic and the multiplier core, and is the only block allowed to restart the core.

## Interface
Parameters:
- WIDTH, 4, operand width; product is 2*WIDTH.
- TMO, 12, watchdog limit in WAIT cycles (used only with MUL_ARB_WDOG_EN).

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- req  in  2  per-requester request level; held until matching gnt bit.
- a_in  in  2*WIDTH  multiplicands, requester i at bits [i*WIDTH +: WIDTH].
- b_in  in  2*WIDTH  multipliers, same packing.
- gnt  out  2  one-cycle grant pulse; operands captured that cycle.
- done  out  2  result valid for requester i; level until ack[i].
- ack  in  2  result consumed.
- res  out  2*WIDTH  product of the served request; valid while done is nonzero.
- err  out  1  watchdog expiry flag; valid while done is nonzero.
- mul_start  out  1  restart pulse to the multiplier core.
- mul_a, mul_b  out  WIDTH each  latched operands to the core.
- mul_fin  in  1  core finish flag.
- mul_p  in  2*WIDTH  core product.

## Operation
- FSM states: IDLE, START, WAIT, RESP. Encoding comes from the package.
- IDLE:
  - If any req bit is set: pick the winner, latch a/b into mul_a/mul_b, latch the owner id, go to START.
  - Otherwise stay in IDLE.
- Round-robin: with both requests set, the requester not served last wins. The last-served pointer resets to 1, so requester 0 wins the first tie. The pointer updates on leaving RESP.
- START:
  - gnt[owner]=1 and mul_start=1 for exactly one cycle.
  - Clear the watchdog counter and go to WAIT.
- WAIT:
  - mul_fin is sampled only in this state.
  - On mul_fin=1: register res<=mul_p and err<=0, then go to RESP.
- RESP:
  - done[owner]=1 while res and err are held.
  - On ack[owner]=1, go to IDLE.
  - ack on the non-owner bit is ignored.
- Requests arriving during START/WAIT/RESP wait; they are arbitrated only in IDLE. There is no IDLE bypass: ack followed by a new request costs one IDLE cycle.
- The non-owner's req stays pending untouched. The owner must drop req after gnt; if req is still high in IDLE, it is treated as a new request.
- Arithmetic is entirely in the core; the block never modifies mul_p.

## Timing
- Reset values: state IDLE, gnt=0, done=0, res=0, err=0, mul_start=0, mul_a=0, mul_b=0, pointer=1, watchdog count=0.
- Reset asserted mid-operation aborts immediately to IDLE without producing done. The core is not touched; the next START restarts it.
- gnt and mul_start assert in the cycle after the edge that samples req in IDLE.
- Latency is core latency + 2 edges. With the team's 8-state control unit (Fin held from S7), done rises 9 edges after the sampling edge.
- ack and done in the same cycle: done drops the next cycle.

## Configuration
- MUL_ARB_WDOG_EN defined:
  - In WAIT, a counter increments each cycle.
  - When it reaches TMO with mul_fin still 0, go to RESP with res=0 and err=1.
  - mul_fin seen in the same cycle as expiry wins, with err=0.
- Undefined: WAIT waits indefinitely, err is tied to 0, and the counter is not built.

## Structure
- Package mul_arb_pkg: state typedef/localparams (IDLE=2'b00, START=2'b01, WAIT=2'b10, RESP=2'b11), N_REQ=2.
- Sub-module mul_arb_rr: combinational 2-way round-robin picker (req, last pointer -> one-hot winner). The registered pointer stays in mul_arbiter.

## Test plan
- Single request: req=2'b01, a=3, b=-2, core model returns -6 -> gnt=01 one cycle, mul_start pulse, done=01 with res=8'hFA at edge 9, cleared the cycle after ack.
- Tie after reset: req=2'b11 -> requester 0 served first. Requester 1 is granted one cycle after the ack, and the pointer then favours 0.
- Back-to-back from the same requester with the other idle -> the same requester is granted again; there is exactly one IDLE cycle between ack and the next gnt.
- Reset in WAIT (cycle 4 after gnt) -> outputs return to reset values next cycle, no done. A later req is serviced normally.
- Watchdog (MUL_ARB_WDOG_EN, TMO=12, mul_fin held 0) -> done with err=1 and res=0 after 12 WAIT cycles. Without the macro, done stays 0 for 100 cycles.
- Wrong-owner ack: done=01, ack=10 -> no state change. ack=01 -> IDLE.
